// File: rtl/sensor_conditioner.sv
// Roadside car-sensor input stage: per-approach synchroniser, debounce counter,
// arrival pulse and sticky request that the light-sequencing FSM clears when it serves.
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic sa_raw,
    input  logic sb_raw,
    input  logic clr_a,
    input  logic clr_b,
    output logic sa_db,
    output logic sb_db,
    output logic rise_a,
    output logic rise_b,
    output logic req_a,
    output logic req_b
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] clr;
    logic [1:0] db;
    logic [1:0] rise;
    logic [1:0] req;

    assign raw = {sb_raw, sa_raw};
    assign clr = {clr_b, clr_a};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic             s1;
        logic             s2;
        logic [CNT_W-1:0] cnt;
        logic             stable;
        logic             rise_r;
        logic             req_r;
        logic             accept;
        logic             rise_next;

        // The counter only reaches CNT_LAST while s2 disagrees, so it can never wrap.
        assign accept    = (s2 != stable) && (cnt == CNT_LAST);
        assign rise_next = accept && s2;

        always_ff @(posedge clk) begin
            if (reset) begin
                s1     <= 1'b0;
                s2     <= 1'b0;
                cnt    <= '0;
                stable <= 1'b0;
                rise_r <= 1'b0;
                req_r  <= 1'b0;
            end else begin
                s1     <= raw[ch];
                s2     <= s1;
                rise_r <= rise_next;
                // Arrival wins over a simultaneous clear so no car is ever dropped.
                req_r  <= rise_next || (req_r && !clr[ch]);
                if (s2 == stable) begin
                    cnt <= '0;
                end else if (accept) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign db[ch]   = stable;
        assign rise[ch] = rise_r;
        assign req[ch]  = req_r;
    end

    assign sa_db  = db[0];
    assign sb_db  = db[1];
    assign rise_a = rise[0];
    assign rise_b = rise[1];
    assign req_a  = req[0];
    assign req_b  = req[1];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: a window-based reference model predicts
// every cycle's outputs into a queue, and an independent monitor pops and compares.
module tb_sensor_conditioner;

    localparam int DC = 4;

    logic clk;
    logic reset;
    logic sa_raw;
    logic sb_raw;
    logic clr_a;
    logic clr_b;
    logic sa_db;
    logic sb_db;
    logic rise_a;
    logic rise_b;
    logic req_a;
    logic req_b;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sa_raw(sa_raw),
        .sb_raw(sb_raw),
        .clr_a(clr_a),
        .clr_b(clr_b),
        .sa_db(sa_db),
        .sb_db(sb_db),
        .rise_a(rise_a),
        .rise_b(rise_b),
        .req_a(req_a),
        .req_b(req_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DC synchronised samples
    // (raw delayed by two sampling edges) all disagree with the accepted level.
    bit raw_hist[2][$];
    bit sync_hist[2][$];
    bit m_stable[2];
    bit m_rise[2];
    bit m_req[2];

    always @(posedge clk) begin : ref_model
        bit raw_now;
        bit clr_now;
        bit synced;
        bit all_diff;
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                raw_hist[ch].delete();
                sync_hist[ch].delete();
                m_stable[ch] = 1'b0;
                m_rise[ch]   = 1'b0;
                m_req[ch]    = 1'b0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                raw_now = (ch == 0) ? sa_raw : sb_raw;
                clr_now = (ch == 0) ? clr_a : clr_b;
                synced  = (raw_hist[ch].size() >= 2) ? raw_hist[ch][raw_hist[ch].size() - 2] : 1'b0;
                raw_hist[ch].push_back(raw_now);
                if (raw_hist[ch].size() > 2) void'(raw_hist[ch].pop_front());
                sync_hist[ch].push_back(synced);
                if (sync_hist[ch].size() > DC) void'(sync_hist[ch].pop_front());
                all_diff = (sync_hist[ch].size() == DC);
                foreach (sync_hist[ch][k]) if (sync_hist[ch][k] == m_stable[ch]) all_diff = 1'b0;
                m_rise[ch] = all_diff && !m_stable[ch];
                if (all_diff) m_stable[ch] = !m_stable[ch];
                m_req[ch] = m_rise[ch] || (m_req[ch] && !clr_now);
            end
        end
        exp_q.push_back({m_stable[1], m_rise[1], m_req[1], m_stable[0], m_rise[0], m_req[0]});
    end

    task automatic check_bit(input string name, input logic act, input logic exp, input int t);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, t, act, exp);
        end
    endtask

    always begin : monitor
        logic [5:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            check_bit("sa_db",  sa_db,  e[2], $time);
            check_bit("rise_a", rise_a, e[1], $time);
            check_bit("req_a",  req_a,  e[0], $time);
            check_bit("sb_db",  sb_db,  e[5], $time);
            check_bit("rise_b", rise_b, e[4], $time);
            check_bit("req_b",  req_b,  e[3], $time);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        sa_raw = 1'b1;
        sb_raw = 1'b1;
        clr_a  = 1'b0;
        clr_b  = 1'b0;
        // reset with both sensors high, then full-latency arrival on both
        cycles(2);
        reset = 1'b0;
        cycles(10);
        // release: level drops after full latency, no pulse, request kept
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        cycles(10);
        clr_a = 1'b1;
        clr_b = 1'b1;
        cycles(1);
        clr_a = 1'b0;
        clr_b = 1'b0;
        cycles(3);
        // clean press on A only; clear with nothing pending is a no-op on B
        sa_raw = 1'b1;
        clr_b  = 1'b1;
        cycles(1);
        clr_b = 1'b0;
        cycles(10);
        // clear A on its own
        clr_a = 1'b1;
        cycles(1);
        clr_a = 1'b0;
        cycles(2);
        // glitch rejection on B: 3 high is too short, 4 high is just accepted
        sb_raw = 1'b1;
        cycles(3);
        sb_raw = 1'b0;
        cycles(10);
        sb_raw = 1'b1;
        cycles(4);
        sb_raw = 1'b0;
        cycles(12);
        // clear on the very edge a new rise appears: request must survive
        sa_raw = 1'b0;
        cycles(10);
        clr_a = 1'b1;
        cycles(1);
        clr_a = 1'b0;
        sa_raw = 1'b1;
        cycles(5);
        clr_a = 1'b1;
        cycles(1);
        clr_a = 1'b0;
        cycles(4);
        // reset mid-count with the sensor still high
        sa_raw = 1'b0;
        cycles(10);
        sa_raw = 1'b1;
        cycles(3);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(12);
        // randomised traffic with mixed glitch lengths, clears and rare resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 15) sa_raw = ~sa_raw;
            if ($urandom_range(0, 99) < 15) sb_raw = ~sb_raw;
            clr_a = ($urandom_range(0, 99) < 8);
            clr_b = ($urandom_range(0, 99) < 8);
            reset = ($urandom_range(0, 399) == 0);
            cycles(1);
        end
        reset = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Input stage for the traffic-light controller. It sits between the raw roadside car sensors and the light-sequencing FSM. For each of the two approaches (A and B), it synchronises the asynchronous sensor line, debounces it with a per-channel counter, and produces a clean level, a one-cycle arrival pulse and a sticky "car waiting" request. The FSM clears each request when it serves that approach. The FSM consumes the debounced `sa_db`/`sb_db` levels or `req_a`/`req_b` in place of raw `sa`/`sb`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronised cycles a new level must persist before it is accepted. Legal range is 2 or more.
- `CNT_W`, default 5: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES - 1.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high. Clears all state on the next rising edge.
- `sa_raw`, in, 1: approach A sensor, asynchronous to `clk`.
- `sb_raw`, in, 1: approach B sensor, asynchronous to `clk`.
- `clr_a`, in, 1: from the FSM; clears `req_a`. Level-sensitive, one cycle is sufficient.
- `clr_b`, in, 1: from the FSM; clears `req_b`.
- `sa_db`, out, 1: debounced level of approach A.
- `sb_db`, out, 1: debounced level of approach B.
- `rise_a`, out, 1: one-cycle pulse when `sa_db` goes 0→1.
- `rise_b`, out, 1: one-cycle pulse when `sb_db` goes 0→1.
- `req_a`, out, 1: sticky request, set by `rise_a` and cleared by `clr_a`.
- `req_b`, out, 1: sticky request, set by `rise_b` and cleared by `clr_b`.

## Operation
The two channels are identical and fully independent. They share no state.

Per-channel state:
- `s1`, `s2`: two-flop synchroniser, with `s1` <= raw and `s2` <= `s1`.
- `cnt[CNT_W-1:0]`: debounce counter.
- `stable`: drives `*_db`.
- `rise`: registered pulse.
- `req`: sticky request.

Debounce rule, evaluated each edge when not in reset:
- If `s2` == `stable`: `cnt` <= 0.
- If `s2` != `stable` and `cnt` == DEBOUNCE_CYCLES-1: `stable` <= `s2` and `cnt` <= 0.
- Otherwise `cnt` <= `cnt` + 1.

Edge detection:
- `rise` <= 1 exactly on the edge where `stable` transitions 0→1. It is 0 on every other edge.
- A 1→0 transition produces no pulse.

Request latch:
- Priority is set over clear: the next value of `req` is `rise_next` OR (`req` AND NOT `clr`).
- A simultaneous arrival and clear leaves `req` = 1, so an arrival is never lost.
- `clr` while `req` = 0 has no effect.

Glitch handling:
- Any `s2` excursion shorter than DEBOUNCE_CYCLES consecutive cycles resets `cnt` and leaves `stable` unchanged.

Counter bounds:
- `cnt` never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.

## Timing
Reset values, on the edge where `reset` = 1:
- `s1`, `s2`, `cnt`, `stable`, `rise` and `req` all go to 0.
- All outputs therefore read 0 after that edge.
- Reset overrides `clr_*` and any in-progress count.

Latency:
- A raw change set up before edge E0 and held steady appears on `*_db` after edge E0 + DEBOUNCE_CYCLES + 1. That is 2 synchroniser edges plus DEBOUNCE_CYCLES counting edges.
- `rise_*` and `req_*` assert on that same edge, so they become visible in the same cycle as `*_db` goes high.
- `rise_*` deasserts on the following edge.

Request clearing:
- `req` clears on the edge where `clr` = 1 is sampled, so it reads 0 in the next cycle.

Reset mid-operation:
- A partial count is discarded.
- If the raw input is still high when `reset` drops, the channel re-debounces from `stable` = 0. It then produces a full-latency rise and sets `req`, treating the car as a new arrival.

Other rules:
- No combinational path from any input to any output. All outputs are registered.
- Throughput: a new accepted level at most once every DEBOUNCE_CYCLES cycles per channel.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.

1. **Reset:** assert `reset` for 2 cycles with `sa_raw` = `sb_raw` = 1. All outputs are 0 during and directly after reset. Release reset. `sa_db`, `rise_a` and `req_a` go high 6 edges later, and `rise_a` is high for exactly 1 cycle.
2. **Clean press:** `sa_raw` 0→1 before edge 0, then held. `sa_db` = 1 after edge 5, `rise_a` high only in the cycle after edge 5, `req_a` = 1. Channel B outputs stay 0 throughout.
3. **Glitch rejection:** `sb_raw` high for 3 cycles, then low for 10 cycles. `sb_db`, `rise_b` and `req_b` stay 0 throughout. `sb_raw` high for 4 cycles, then low: `sb_db` pulses high and `req_b` = 1.
4. **Clear versus set:**
   - `req_a` = 1, then `clr_a` pulsed for one cycle: `req_a` = 0 in the next cycle.
   - `clr_a` = 1 on the same edge as a new rise: `req_a` = 1 afterwards.
5. **Release:** after `sa_db` = 1, drop `sa_raw`. `sa_db` = 0 after 6 edges, with no `rise_a` and `req_a` unchanged.
6. **Reset mid-count:** `sa_raw` high, then `reset` pulsed at edge 3. No rise is seen before a full 6-edge debounce measured from the release of reset.
